if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the RV32I pipeline, directly upstream of the decode/control stage. It owns the fetch PC and drives the instruction-memory read handshake with at most one request outstanding. Fetched {pc, insn} pairs are buffered in a small FIFO that feeds decode. Branch/jump redirects from execute flush the FIFO and squash any stale in-flight response.

Parameters:
RESET_PC, 32'h0000_0060, fetch address of the first request after reset.
FIFO_DEPTH, 2, number of {pc, insn} entries buffered toward decode (power of 2, at least 2).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
imem_read  out  1  read request; held high until imem_resp.
imem_address  out  32  request address; stable while imem_read is high; bits [1:0] always 0.
imem_rdata  in  32  instruction word; valid when imem_resp is high.
imem_resp  in  1  one-cycle completion pulse for the outstanding read.
redirect  in  1  execute-stage redirect (taken branch, jal, jalr).
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
id_stall  in  1  decode cannot accept the head entry this cycle.
if_valid  out  1  head entry valid toward decode.
if_insn  out  32  head instruction word.
if_pc  out  32  head PC.

Behaviour:
- Reset: clk and rst are the only clock and reset; reset is synchronous and active-high. While rst is high at a clock edge: state <= IDLE, fetch_pc <= RESET_PC, req_addr <= RESET_PC, FIFO count <= 0. Outputs during and after reset: imem_read = 0, if_valid = 0, if_insn = 0, if_pc = 0. A reset arriving mid-request abandons the request. The memory side must tolerate imem_read falling before imem_resp.
- Registers: fetch_pc (next address to request), req_addr (drives imem_address), state, FIFO storage, rd_ptr, wr_ptr, count.
- FIFO outputs: if_valid = (count != 0), and if_insn/if_pc are the head entry, all driven from registers. Pop when if_valid && !id_stall && !redirect. Push on an accepted response. Push and pop may occur in the same cycle. Pointers wrap modulo FIFO_DEPTH.
- IDLE: imem_read = 0. If count_next < FIFO_DEPTH, then req_addr <= fetch_pc and the state moves to REQ; otherwise the state stays IDLE.
- REQ: imem_read = 1, imem_address = req_addr.
  - On imem_resp without redirect: push {req_addr, imem_rdata} and set fetch_pc <= req_addr + 4 (wraps modulo 2^32). If count_next < FIFO_DEPTH, set req_addr <= req_addr + 4 and stay in REQ (back-to-back request, new address on the next cycle). Otherwise go to IDLE.
  - On redirect without imem_resp: fetch_pc <= redirect_pc & ~3, go to DRAIN. req_addr is held because the address must stay stable.
  - On redirect and imem_resp in the same cycle: the response is dropped (not pushed), req_addr <= fetch_pc <= redirect_pc & ~3, and the state stays in REQ.
- DRAIN: imem_read = 1 at the stale req_addr.
  - On imem_resp: discard the data, set req_addr <= fetch_pc, go to REQ.
  - A further redirect while in DRAIN overwrites fetch_pc with the newest target, and the state stays in DRAIN.
- Redirect in any state: the FIFO is flushed (count, rd_ptr, wr_ptr <= 0), so if_valid = 0 from the next cycle. No pop occurs in the redirect cycle. Decode squashes whatever it holds during the redirect cycle.
- Latency: from imem_resp to the entry appearing at the FIFO output is 1 cycle. With a 1-cycle memory, throughput is 1 instruction every 2 cycles; each additional cycle of memory latency adds 1 cycle.
- Full FIFO: no request is issued while count == FIFO_DEPTH. A request is only issued when there is room, so overflow is impossible. An imem_resp arriving while in IDLE is a protocol error: it is ignored and asserts in simulation.
- Empty FIFO: if_valid = 0. id_stall is ignored.

Optional Feature:
IF_PERF_CNT_EN: when defined, adds three 32-bit outputs, each reset to 0 and saturating at 2^32-1:
- perf_fetched: counts accepted pushes.
- perf_squashed: counts responses dropped in the redirect cycle or in DRAIN, plus valid FIFO entries flushed by a redirect.
- perf_starved: counts cycles with if_valid == 0 && rst == 0.
When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then a memory that answers in 1 cycle with id_stall = 0 -> first imem_address = 0x60, then 0x64 and 0x68. if_pc sequence 0x60, 0x64, 0x68 with matching if_insn values, no gaps beyond one per 2 cycles.
- id_stall held high for 10 cycles -> exactly 2 entries buffered (0x60 and 0x64), imem_read low, count = 2. Release id_stall -> 0x60 delivered, then 0x64, and a fetch of 0x68 is issued.
- Redirect to 0x200 while the 0x64 request waits 3 cycles for its response -> state enters DRAIN, 0x64 data never appears on if_insn, next imem_address = 0x200, first valid if_pc = 0x200.
- Redirect to 0x300 in the same cycle as imem_resp for 0x68 -> 0x68 is not pushed, FIFO flushed, next imem_address = 0x300.
- Two redirects while in DRAIN (to 0x400, then 0x500) -> after the stale response, the next request goes to 0x500 only.
- rst asserted while imem_read = 1 at 0x64 -> the following cycle has imem_read = 0 and if_valid = 0, and after reset the first request is again 0x60. Under IF_PERF_CNT_EN, all counters read 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// RV32I fetch stage: one outstanding imem read, {pc, insn} FIFO toward decode, redirect squash.
// Define IF_PERF_CNT_EN to add saturating perf_fetched / perf_squashed / perf_starved counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0060,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_insn,
  output logic [31:0] if_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed,
  output logic [31:0] perf_starved
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } entry_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   req_addr, req_addr_next;
  entry_t        fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop, room;
  logic [31:0]   redir_tgt, seq_pc;

  assign redir_tgt    = redirect_pc & ~32'd3;
  assign seq_pc       = req_addr + 32'd4;
  assign imem_read    = (state != IDLE);
  assign imem_address = req_addr;

  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? fifo_q[rd_ptr].pc   : 32'd0;
  assign if_insn  = if_valid ? fifo_q[rd_ptr].insn : 32'd0;

  // Responses are only accepted in REQ; anything arriving in DRAIN belongs to a squashed fetch.
  assign push = (state == REQ) && imem_resp && !redirect;
  assign pop  = if_valid && !id_stall && !redirect;

  always_comb begin
    count_next = count;
    if (redirect) count_next = '0;
    else          count_next = count + CW'(push) - CW'(pop);
  end

  assign room = (count_next < CW'(FIFO_DEPTH));

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_next = redir_tgt;
          req_addr_next = redir_tgt;
          state_next    = REQ;
        end else if (room) begin
          req_addr_next = fetch_pc;
          state_next    = REQ;
        end
      end
      REQ: begin
        if (redirect && imem_resp) begin
          fetch_pc_next = redir_tgt;
          req_addr_next = redir_tgt;
        end else if (redirect) begin
          // address must stay stable until the in-flight read returns
          fetch_pc_next = redir_tgt;
          state_next    = DRAIN;
        end else if (imem_resp) begin
          fetch_pc_next = seq_pc;
          if (room) req_addr_next = seq_pc;
          else      state_next    = IDLE;
        end
      end
      DRAIN: begin
        if (redirect) fetch_pc_next = redir_tgt;
        if (imem_resp) begin
          req_addr_next = redirect ? redir_tgt : fetch_pc;
          state_next    = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
      count    <= count_next;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: req_addr, insn: imem_rdata};
  end

  a_no_resp_in_idle: assert property (@(posedge clk) disable iff (rst) !(state == IDLE && imem_resp));

`ifdef IF_PERF_CNT_EN
  logic        drop;
  logic [31:0] squash_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign drop       = imem_resp && ((state == REQ && redirect) || state == DRAIN);
  assign squash_inc = (redirect ? 32'(count) : 32'd0) + 32'(drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
      perf_starved  <= '0;
    end else begin
      perf_fetched  <= sat_add(perf_fetched, 32'(push));
      perf_squashed <= sat_add(perf_squashed, squash_inc);
      perf_starved  <= sat_add(perf_starved, 32'(!if_valid));
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random stall/redirect/latency traffic,
// checked against a program-order instruction-stream model with a FIFO occupancy count.
`timescale 1ns/1ps
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0060;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_insn, if_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed, perf_starved;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_stall(id_stall),
    .if_valid(if_valid), .if_insn(if_insn), .if_pc(if_pc)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed), .perf_starved(perf_starved)
`endif
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5A_0013;
  endfunction

  // memory responder
  bit          busy, stale, lat_rand;
  int          wcnt, lat = 1;
  logic [31:0] cap_addr;
  // decode-side knobs
  bit          stall_force, rnd, rd_req, rd_on_resp;
  logic [31:0] rd_tgt;
  // reference model: next expected pc in program order, and FIFO occupancy
  logic [31:0] exp_pc;
  int occ, occ_nx;
  int m_fetched, m_squashed, m_starved, p_fetched, p_squashed, p_starved;
  int cyc, gap, max_gap;
  logic [31:0] addr_log[$], acc_log[$];
  int acc_cyc[$], resp_cyc[$];

  task automatic chk_perf();
`ifdef IF_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'(m_fetched));
    chk("perf_squashed", perf_squashed, 32'(m_squashed));
    chk("perf_starved", perf_starved, 32'(m_starved));
`endif
  endtask

  task automatic cycle();
    bit stall, redir, acc, push;
    logic [31:0] tgt;
    @(negedge clk);
    cyc++;
    occ = occ_nx;
    m_fetched += p_fetched; m_squashed += p_squashed; m_starved += p_starved;
    chk("if_valid", {31'd0, if_valid}, {31'd0, occ != 0});

    if (imem_resp) begin
      imem_resp = 1'b0;
      busy = 1'b0;
    end
    if (!imem_read) busy = 1'b0;
    else if (busy) begin
      chk("addr_stable", imem_address, cap_addr);
      wcnt--;
      if (wcnt == 0) begin
        imem_resp = 1'b1;
        imem_rdata = insn_of(cap_addr);
        resp_cyc.push_back(cyc);
      end
    end else begin
      busy = 1'b1; stale = 1'b0; cap_addr = imem_address;
      wcnt = lat_rand ? int'($urandom_range(1, 3)) : lat;
      addr_log.push_back(imem_address);
      chk("addr_align", {30'd0, imem_address[1:0]}, 32'd0);
    end

    stall = stall_force || (rnd && $urandom_range(0, 99) < 25);
    redir = 1'b0; tgt = '0;
    if (rd_req && (!rd_on_resp || imem_resp)) begin
      redir = 1'b1; tgt = rd_tgt; rd_req = 1'b0;
    end else if (rnd && $urandom_range(0, 99) < 4) begin
      redir = 1'b1;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_3FFF);
    end

    acc = (occ != 0) && !stall && !redir;
    if (acc) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_insn", if_insn, insn_of(exp_pc));
      acc_log.push_back(if_pc); acc_cyc.push_back(cyc);
      exp_pc += 32'd4; gap = 0;
    end else begin
      gap++;
      if (rnd && gap > max_gap) max_gap = gap;
    end

    push = imem_resp && !redir && !stale;
    p_fetched  = int'(push);
    p_squashed = int'(imem_resp && (redir || stale)) + (redir ? occ : 0);
    p_starved  = int'(occ == 0);
    occ_nx = redir ? 0 : occ + int'(push) - int'(acc);
    if (redir) begin
      exp_pc = tgt & ~32'd3;
      if (busy && !imem_resp) stale = 1'b1;
    end
    id_stall = stall; redirect = redir; redirect_pc = tgt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_resp = 1'b0; redirect = 1'b0; id_stall = 1'b0;
    busy = 1'b0; stale = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    chk("rst_imem_read", {31'd0, imem_read}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_insn", if_insn, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    m_fetched = 0; m_squashed = 0; m_starved = 0;
    chk_perf();
    @(negedge clk);
    rst = 1'b0;
    exp_pc = RESET_PC; occ_nx = 0;
    p_fetched = 0; p_squashed = 0; p_starved = 1;
    addr_log.delete(); acc_log.delete(); acc_cyc.delete(); resp_cyc.delete();
    cyc = 0; gap = 0;
  endtask

  task automatic wait_addr(input int n, input int budget);
    for (int i = 0; i < budget && addr_log.size() < n; i++) cycle();
    chk("wait_addr", 32'(addr_log.size()), 32'(n));
  endtask

  task automatic wait_acc(input int n, input int budget);
    for (int i = 0; i < budget && acc_log.size() < n; i++) cycle();
    chk("wait_acc", 32'(acc_log.size()), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // 1-cycle memory, no stalls: one instruction every 2 cycles
    do_reset(); lat = 1;
    repeat (12) cycle();
    chk("first_addr", addr_log[0], 32'h60);
    chk("second_addr", addr_log[1], 32'h64);
    chk("third_addr", addr_log[2], 32'h68);
    chk("tput_gap0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
    chk("tput_gap1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
    chk("resp_to_valid", 32'(acc_cyc[0] - resp_cyc[0]), 32'd1);
    chk_perf();

    // decode stalled: FIFO fills to 2 and fetch stops
    do_reset(); lat = 1; stall_force = 1'b1;
    repeat (10) cycle();
    chk("full_req_count", 32'(addr_log.size()), 32'd2);
    chk("full_imem_read", {31'd0, imem_read}, 32'd0);
    stall_force = 1'b0;
    repeat (4) cycle();
    chk("drain_back2back", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    chk("refill_addr", addr_log[2], 32'h68);
    chk_perf();

    // redirect while 0x64 is outstanding on a slow memory
    do_reset(); lat = 3;
    wait_addr(2, 30);
    rd_req = 1'b1; rd_on_resp = 1'b0; rd_tgt = 32'h200;
    cycle();
    wait_addr(3, 30);
    chk("drain_next_addr", addr_log[2], 32'h200);
    wait_acc(2, 30);
    chk("drain_first_pc", acc_log[1], 32'h200);
    chk_perf();

    // redirect coinciding with the response for 0x68
    do_reset(); lat = 1;
    wait_addr(3, 30);
    rd_req = 1'b1; rd_on_resp = 1'b1; rd_tgt = 32'h300;
    wait_addr(4, 30);
    chk("same_cycle_addr", addr_log[3], 32'h300);
    wait_acc(3, 30);
    chk("same_cycle_pc", acc_log[2], 32'h300);
    chk_perf();
    rd_on_resp = 1'b0;

    // two redirects inside DRAIN; the second target has low bits set
    do_reset(); lat = 4;
    wait_addr(2, 30);
    rd_req = 1'b1; rd_tgt = 32'h400; cycle();
    rd_req = 1'b1; rd_tgt = 32'h502; cycle();
    wait_addr(3, 30);
    chk("double_redir_addr", addr_log[2], 32'h500);
    wait_acc(2, 30);
    chk("double_redir_pc", acc_log[1], 32'h500);
    chk_perf();

    // reset in the middle of the 0x64 read
    do_reset(); lat = 3;
    wait_addr(2, 30);
    chk("pre_rst_read", {31'd0, imem_read}, 32'd1);
    chk("pre_rst_addr", imem_address, 32'h64);
    do_reset();
    wait_addr(1, 10);
    chk("post_rst_addr", addr_log[0], 32'h60);

    // random traffic
    do_reset(); rnd = 1'b1; lat_rand = 1'b1; max_gap = 0;
    repeat (3000) cycle();
    chk("max_gap_bounded", {31'd0, max_gap < 100}, 32'd1);
    chk("random_progress", {31'd0, acc_log.size() > 200}, 32'd1);
    chk_perf();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
